// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter: shares one AXI3 master port between an instruction-fetch and a data SRAM-like requester.
// Ports: aclk/aresetn (async active-low); inst_* fetch handshake; data_* read/write handshake;
// ar*/r* read channels, aw*/w*/b* write channels (constant AXI fields are tied off at top level).
// Optional: ARB_ROUND_ROBIN_EN replaces fixed data-over-inst read priority with round-robin.
module sram_axi_arbiter #(
    parameter logic [3:0] INST_ARID = 4'd0,
    parameter logic [3:0] DATA_ARID = 4'd1,
    parameter logic [3:0] WR_ID     = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    ar_state_t ar_state, ar_next;
    w_state_t  w_state, w_next;
    logic        i_rd_pend, d_rd_pend, w_pend;
    logic [29:0] w_addr;
    logic        d_cand, i_cand, d_gnt, i_gnt, w_gnt;
    logic        r_inst, r_data, b_done;

    // A fetch may not read the word an in-flight store is about to change.
    assign d_cand = data_req & ~data_wr & ~d_rd_pend & ~w_pend;
    assign i_cand = inst_req & ~i_rd_pend & ~(w_pend & (inst_addr[31:2] == w_addr));

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
    // last_grant: 0 = inst granted last, 1 = data granted last
    assign d_gnt = (ar_state == AR_IDLE) & d_cand & (~i_cand | ~last_grant);
    assign i_gnt = (ar_state == AR_IDLE) & i_cand & (~d_cand | last_grant);
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn)
            last_grant <= 1'b0;
        else if (d_gnt | i_gnt)
            last_grant <= d_gnt;
`else
    assign d_gnt = (ar_state == AR_IDLE) & d_cand;
    assign i_gnt = (ar_state == AR_IDLE) & i_cand & ~d_cand;
`endif

    assign w_gnt  = (w_state == W_IDLE) & data_req & data_wr & ~d_rd_pend & ~d_gnt;
    assign r_inst = rvalid & rready & (rid == INST_ARID);
    assign r_data = rvalid & rready & (rid == DATA_ARID);
    assign b_done = (w_state == W_RESP) & bvalid;

    // State registers
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            ar_state <= AR_IDLE;
            w_state  <= W_IDLE;
        end else begin
            ar_state <= ar_next;
            w_state  <= w_next;
        end

    // Next-state logic
    always_comb begin
        ar_next = ar_state;
        w_next  = w_state;
        if (ar_state == AR_IDLE && (d_gnt || i_gnt))
            ar_next = AR_SEND;
        else if (ar_state == AR_SEND && arready)
            ar_next = AR_IDLE;
        case (w_state)
            W_IDLE: if (w_gnt) w_next = W_SEND;
            // each channel is done once its valid has dropped or is handshaking now
            W_SEND: if ((~awvalid | awready) && (~wvalid | wready)) w_next = W_RESP;
            W_RESP: if (bvalid) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        inst_addr_ok = i_gnt;
        data_addr_ok = d_gnt | w_gnt;
        inst_data_ok = r_inst;
        data_data_ok = r_data | b_done;
        arvalid      = (ar_state == AR_SEND);
        bready       = (w_state == W_RESP);
    end

    assign inst_rdata = rdata;
    assign data_rdata = rdata;
    assign awid       = WR_ID;
    assign wid        = WR_ID;
    assign wlast      = 1'b1;

    // Datapath and pending tracking; completion clears before a new grant sets.
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            araddr    <= '0;
            arsize    <= '0;
            arid      <= '0;
            awaddr    <= '0;
            awsize    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            rready    <= 1'b0;
            i_rd_pend <= 1'b0;
            d_rd_pend <= 1'b0;
            w_pend    <= 1'b0;
            w_addr    <= '0;
        end else begin
            rready <= 1'b1;
            if (d_gnt | i_gnt) begin
                araddr <= d_gnt ? data_addr : inst_addr;
                arsize <= {1'b0, d_gnt ? data_size : inst_size};
                arid   <= d_gnt ? DATA_ARID : INST_ARID;
            end
            if (r_inst) i_rd_pend <= 1'b0;
            if (i_gnt)  i_rd_pend <= 1'b1;
            if (r_data) d_rd_pend <= 1'b0;
            if (d_gnt)  d_rd_pend <= 1'b1;
            if (b_done) w_pend <= 1'b0;
            if (w_gnt) begin
                w_pend  <= 1'b1;
                w_addr  <= data_addr[31:2];
                awaddr  <= data_addr;
                awsize  <= {1'b0, data_size};
                wdata   <= data_wdata;
                wstrb   <= data_wstrb;
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
            end else begin
                if (awready) awvalid <= 1'b0;
                if (wready)  wvalid  <= 1'b0;
            end
        end
endmodule

// File: tb/tb_sram_axi_arbiter.sv
// tb_sram_axi_arbiter: directed-vector self-checking bench for sram_axi_arbiter.
module tb_sram_axi_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        aclk = 1'b0, aresetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic [1:0]  inst_size;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [3:0]  arid, rid, awid, wid, wstrb;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready;
    int n_vec = 0, n_err = 0;

    sram_axi_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        inst_req = 0; inst_addr = 0; inst_size = 2'd2;
        data_req = 0; data_wr = 0; data_addr = 0; data_size = 2'd2; data_wstrb = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        repeat (2) @(negedge aclk);
        #1;
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("wlast", wlast, 1);
        @(negedge aclk) aresetn = 1'b1;
        @(negedge aclk); #1 check("rready_on", rready, 1);

        // fetch only
        @(negedge aclk) inst_req = 1; inst_addr = 32'h1C00_0000;
        #1 check("f_addr_ok", inst_addr_ok, 1); check("f_d_addr_ok", data_addr_ok, 0);
        @(negedge aclk) inst_req = 0;
        #1 check("f_arvalid", arvalid, 1); check("f_araddr", araddr, 32'h1C00_0000);
        check("f_arid", arid, 0); check("f_arsize", arsize, 2);
        @(negedge aclk) arready = 1;
        #1 check("f_ar_hold", arvalid, 1); check("f_ar_hold_addr", araddr, 32'h1C00_0000);
        @(negedge aclk) arready = 0; rvalid = 1; rid = 0; rdata = 32'h0280_0000;
        #1 check("f_ar_drop", arvalid, 0); check("f_data_ok", inst_data_ok, 1);
        check("f_rdata", inst_rdata, 32'h0280_0000); check("f_d_data_ok", data_data_ok, 0);

        // both requesters
        @(negedge aclk) rvalid = 0; data_req = 1; data_wr = 0; data_addr = 32'h0000_1000;
        inst_req = 1; inst_addr = 32'h1C00_0004;
        #1 check("b1_d_ok", data_addr_ok, 1); check("b1_i_ok", inst_addr_ok, 0);
        @(negedge aclk) data_req = 0; inst_req = 0; arready = 1;
        #1 check("b1_arid", arid, 1); check("b1_araddr", araddr, 32'h0000_1000);
        @(negedge aclk) arready = 0; rvalid = 1; rid = 1; rdata = 32'h1111_2222;
        #1 check("b1_d_data_ok", data_data_ok, 1); check("b1_d_rdata", data_rdata, 32'h1111_2222);
        check("b1_i_data_ok", inst_data_ok, 0);
        @(negedge aclk) rvalid = 0; data_req = 1; inst_req = 1;
        #1 check("b2_d_ok", data_addr_ok, RR ? 0 : 1); check("b2_i_ok", inst_addr_ok, RR ? 1 : 0);
        @(negedge aclk) arready = 1;
        #1 check("b2_arid", arid, RR ? 0 : 1); check("send_no_i_gnt", inst_addr_ok, 0);
        check("send_no_d_gnt", data_addr_ok, 0);
        @(negedge aclk) arready = 0;
        #1 check("b3_i_ok", inst_addr_ok, RR ? 0 : 1); check("b3_d_ok", data_addr_ok, RR ? 1 : 0);
        @(negedge aclk) data_req = 0; inst_req = 0; arready = 1;
        #1 check("b3_arid", arid, RR ? 1 : 0);
        @(negedge aclk) arready = 0; rvalid = 1; rid = 4'd7;
        #1 check("stray_i", inst_data_ok, 0); check("stray_d", data_data_ok, 0);
        @(negedge aclk) rvalid = 0; inst_req = 1; data_req = 1;
        #1 check("pend_i_block", inst_addr_ok, 0); check("pend_d_block", data_addr_ok, 0);
        @(negedge aclk) inst_req = 0; data_req = 0; rvalid = 1; rid = 0;
        #1 check("b_i_ret", inst_data_ok, 1);
        @(negedge aclk) rid = 1;
        #1 check("b_d_ret", data_data_ok, 1);

        // store with awready two cycles ahead of wready
        @(negedge aclk) rvalid = 0; data_req = 1; data_wr = 1; data_addr = 32'h0000_2000;
        data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
        #1 check("w_addr_ok", data_addr_ok, 1);
        @(negedge aclk) data_req = 0; awready = 1;
        #1 check("w_awvalid", awvalid, 1); check("w_wvalid", wvalid, 1);
        check("w_awaddr", awaddr, 32'h0000_2000); check("w_wdata", wdata, 32'hDEAD_BEEF);
        check("w_wstrb", wstrb, 4'hF); check("w_awid", awid, 1); check("w_wid", wid, 1);
        check("w_awsize", awsize, 2);
        @(negedge aclk) awready = 0;
        #1 check("w_aw_drop", awvalid, 0); check("w_w_hold", wvalid, 1); check("w_bready0", bready, 0);
        @(negedge aclk) wready = 1;
        #1 check("w_bready1", bready, 0);
        @(negedge aclk) wready = 0;
        #1 check("w_w_drop", wvalid, 0); check("w_resp", bready, 1); check("w_no_ok", data_data_ok, 0);
        @(negedge aclk) bvalid = 1;
        #1 check("w_data_ok", data_data_ok, 1);
        @(negedge aclk) bvalid = 0;
        #1 check("w_idle", bready, 0);

        // fetch/write hazard
        @(negedge aclk) data_req = 1; data_wr = 1; data_addr = 32'h1C00_0010;
        #1 check("h_w_ok", data_addr_ok, 1);
        @(negedge aclk) data_req = 0; inst_req = 1; inst_addr = 32'h1C00_0010;
        #1 check("hazard_block", inst_addr_ok, 0);
        @(negedge aclk) inst_addr = 32'h1C00_0014;
        #1 check("hazard_other", inst_addr_ok, 1);
        @(negedge aclk) inst_req = 0; arready = 1; awready = 1; wready = 1;
        #1 check("h_araddr", araddr, 32'h1C00_0014);
        @(negedge aclk) arready = 0; awready = 0; wready = 0; inst_req = 1; inst_addr = 32'h1C00_0010;
        #1 check("h_bready", bready, 1); check("h_still_block", inst_addr_ok, 0);
        @(negedge aclk) bvalid = 1; rvalid = 1; rid = 0;
        #1 check("h_b_ok", data_data_ok, 1); check("h_r_ok", inst_data_ok, 1);
        @(negedge aclk) bvalid = 0; rvalid = 0;
        #1 check("hazard_release", inst_addr_ok, 1);
        @(negedge aclk) inst_req = 0; arready = 1;
        @(negedge aclk) arready = 0; rvalid = 1; rid = 0;
        @(negedge aclk) rvalid = 0;

        // asynchronous reset mid-transaction
        @(negedge aclk) inst_req = 1; inst_addr = 32'h1C00_0020;
        data_req = 1; data_wr = 1; data_addr = 32'h0000_3000;
        #1 check("r_i_ok", inst_addr_ok, 1); check("r_w_ok", data_addr_ok, 1);
        @(negedge aclk) inst_req = 0; data_req = 0;
        #1 check("r_arvalid", arvalid, 1); check("r_awvalid", awvalid, 1);
        #2 aresetn = 0;
        #1 check("ar_arvalid", arvalid, 0); check("ar_awvalid", awvalid, 0);
        check("ar_wvalid", wvalid, 0); check("ar_bready", bready, 0); check("ar_rready", rready, 0);
        @(negedge aclk) aresetn = 1; data_req = 1; data_wr = 0; data_addr = 32'h0000_1000;
        inst_req = 1; inst_addr = 32'h1C00_0020;
        #1 check("post_d_ok", data_addr_ok, 1); check("post_i_ok", inst_addr_ok, 0);
        @(negedge aclk) data_req = 0; arready = 1;
        @(negedge aclk) arready = 0;
        #1 check("post_ipend_clr", inst_addr_ok, 1);
        inst_req = 0;
        @(negedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sram_axi_arbiter.md
Name: sram_axi_arbiter

Overview:
- Shares one AXI3 master port between two SRAM-like requesters.
  - Instruction fetch: read-only.
  - Data: read or write.
- Sits between the CPU pipeline and the AXI interface at the top level, alongside the IF/EXE/MEM stages.
- Sequences the AR, AW/W and B channels with independent read and write FSMs.
- Blocks a fetch that would read a word with a write still in flight.
- Constant AXI fields (arlen, arburst, arlock, arcache, arprot and their aw/w equivalents) are tied at top level and are not driven here.

Parameters:
INST_ARID, 4'd0, arid used for instruction reads
DATA_ARID, 4'd1, arid used for data reads
WR_ID, 4'd1, awid/wid used for data writes

Ports:
aclk  in  1  clock
aresetn  in  1  reset: asynchronous, active-low
inst_req / inst_addr_ok / inst_data_ok  in / out / out  1 each  instruction handshake
inst_addr / inst_size / inst_rdata  in / in / out  32 / 2 / 32  instruction address, size, read data
data_req / data_wr / data_addr_ok / data_data_ok  in / in / out / out  1 each  data handshake
data_addr / data_size / data_wstrb / data_wdata / data_rdata  in / in / in / in / out  32 / 2 / 4 / 32 / 32  data request fields and read data
arid / araddr / arsize / arvalid / arready  out / out / out / out / in  4 / 32 / 3 / 1 / 1  read address channel
rid / rdata / rvalid / rready  in / in / in / out  4 / 32 / 1 / 1  read data channel
awid / awaddr / awsize / awvalid / awready  out / out / out / out / in  4 / 32 / 3 / 1 / 1  write address channel
wid / wdata / wstrb / wlast / wvalid / wready  out / out / out / out / out / in  4 / 32 / 4 / 1 / 1 / 1  write data channel
bvalid / bready  in / out  1 / 1  write response channel

Behaviour:
- Reset (asynchronous, aresetn low): clears all state immediately, including mid-transaction.
  - Registered outputs return to 0: arvalid, awvalid, wvalid, bready, rready, araddr, arsize, arid, awaddr, wdata, wstrb.
  - rready is 1 from the first cycle after reset release.
  - wlast is constant 1.
- Pending state:
  - i_rd_pend, d_rd_pend: one outstanding read per requester.
  - w_pend plus w_addr[31:2]: outstanding write.
  - The data port allows only one outstanding transaction of either kind, so data ordering is implicit.
- Read FSM:
  - AR_IDLE → AR_SEND when a read is granted.
  - Data candidate: data_req & ~data_wr & ~d_rd_pend & ~w_pend.
  - Inst candidate: inst_req & ~i_rd_pend & ~(w_pend & inst_addr[31:2]==w_addr).
  - Fixed priority: data over inst.
  - On grant in the same cycle:
    - the winner's addr_ok is combinationally 1;
    - latch araddr, arsize={1'b0,size} and arid, and assert arvalid;
    - set the winner's pending flag.
  - AR_SEND: hold arvalid and all ar fields stable until arready; then arvalid=0 and return to AR_IDLE. No grants are issued in AR_SEND.
- Read return:
  - rvalid & rid==INST_ARID → inst_data_ok=1, inst_rdata=rdata, clear i_rd_pend.
  - rvalid & rid==DATA_ARID → data_data_ok=1, clear d_rd_pend.
  - Any other rid is accepted and dropped.
  - data_rdata = inst_rdata = rdata, combinational.
- Write FSM:
  - W_IDLE: data_req & data_wr & ~d_rd_pend, and no data read grant this cycle → data_addr_ok=1.
    - Latch awaddr, awsize, wdata, wstrb; set w_pend and w_addr.
    - Assert awvalid and wvalid; go to W_SEND.
  - W_SEND: awvalid drops on awready and wvalid drops on wready, independently.
    - When both handshakes are done (including the same cycle) → W_RESP with bready=1.
  - W_RESP: on bvalid → data_data_ok=1, bready=0, clear w_pend, go to W_IDLE.
  - bresp is ignored.
- Simultaneous events:
  - bvalid and a data-read rvalid cannot coincide by construction.
  - An inst rvalid and a bvalid in the same cycle are both served.
  - Grant and completion of the same requester in one cycle: completion clears the flag, then the new grant sets it.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_grant register (reset 0 = inst) picks the requester not last granted whenever both are eligible in AR_IDLE. It updates on every grant.
- Undefined: fixed data-over-inst priority, and the register is absent.

Test Plan:
- Fetch only:
  - inst_req addr 0x1C000000 → inst_addr_ok in the same cycle; arvalid araddr=0x1C000000 arid=0 held until arready.
  - rvalid rid=0 rdata=0x02800000 → inst_data_ok=1, inst_rdata=0x02800000.
- Both requesters in the same cycle (data read 0x00001000 and inst 0x1C000004):
  - Without the macro, data is granted first (arid=1) and inst in the next AR_IDLE.
  - With the macro, the grant alternates.
- Store 0x00002000 wstrb=0xF wdata=0xDEADBEEF:
  - awready arrives 2 cycles before wready → W_RESP only after both.
  - bvalid → data_data_ok=1.
- Hazard: write pending to 0x1C000010, then inst_req 0x1C000010 → inst_addr_ok=0 until bvalid. Meanwhile inst_req 0x1C000014 is granted.
- Stray rid=4'd7 rvalid → no data_ok; pending flags unchanged.
- aresetn driven low during AR_SEND and W_SEND → arvalid, awvalid, wvalid, bready and all pending flags are 0 immediately; the next request after release is granted normally.
